// File: rtl/lab3_pkg.sv
// lab3_pkg -- definitions shared by the state sequencer and the downstream
// manual/memory state selector.
//   STATE_W       : width of one recorded state value
//   DEPTH_DEFAULT : default number of sequence memory entries
//   seq_state_t   : sequencer FSM encoding (IDLE, PLAY, HOLD)
package lab3_pkg;

  localparam int STATE_W       = 3;
  localparam int DEPTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2
  } seq_state_t;

endpackage

// File: rtl/tick_gen.sv
// tick_gen -- playback prescaler. Counts 0..TICK_DIV-1 while enabled and
// asserts tick on the cycle the count sits at TICK_DIV-1, wrapping to 0.
// Dropping en returns the count to 0, so every enable starts a full period.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   en    : count enable
//   tick  : one-cycle step strobe (combinational from the count)
module tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en & (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/state_sequencer.sv
// state_sequencer -- records a sequence of manually selected states and plays
// it back, one entry per TICK_DIV clock cycles.
// Build option: define SEQ_LOOP_EN to make playback wrap from the last entry
// back to the first forever; otherwise playback stops in HOLD on the last
// entry and raises done.
// Ports:
//   clk              : system clock, rising edge
//   reset            : synchronous active-high reset (discards the sequence)
//   run              : 1 = play back, 0 = idle (recording allowed)
//   rec_key          : debounced record button level; each rising edge records
//   clear            : one-cycle pulse emptying the sequence
//   state_in         : state value to record
//   CurrentState_mem : registered playback output (0 when idle or empty)
//   seq_len          : number of stored entries, 0..DEPTH
//   full             : seq_len == DEPTH
//   done             : playback reached the last entry (non-loop build only)
module state_sequencer
  import lab3_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int DEPTH    = DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               rec_key,
  input  logic               clear,
  input  logic [STATE_W-1:0] state_in,
  output logic [STATE_W-1:0] CurrentState_mem,
  output logic [3:0]         seq_len,
  output logic               full,
  output logic               done
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  seq_state_t         state;
  logic [STATE_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               rec_d;
  logic               rec_edge;
  logic               wr_en;
  logic               tick_en;
  logic               tick;
  logic               at_last;

  assign full     = (seq_len == 4'(DEPTH));
  assign rec_edge = rec_key & ~rec_d;
  // clear wins over a same-cycle record request
  assign wr_en    = (state == IDLE) & rec_edge & ~full & ~clear;
  // Gating with run/clear zeroes the prescaler on the same edge that leaves PLAY
  assign tick_en  = (state == PLAY) & run & ~clear;
  assign at_last  = (4'(rd_ptr) == (seq_len - 4'd1));

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .en   (tick_en),
    .tick (tick)
  );

  // Sequence storage; contents survive reset and clear, only seq_len matters
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[wr_ptr] <= state_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      seq_len          <= '0;
      done             <= 1'b0;
      CurrentState_mem <= '0;
      rec_d            <= 1'b0;
    end else begin
      rec_d <= rec_key;
      if (clear) begin
        state            <= IDLE;
        wr_ptr           <= '0;
        rd_ptr           <= '0;
        seq_len          <= '0;
        done             <= 1'b0;
        CurrentState_mem <= '0;
      end else begin
        if (wr_en) begin
          wr_ptr  <= wr_ptr + PW'(1);
          seq_len <= seq_len + 4'd1;
        end
        case (state)
          IDLE: begin
            CurrentState_mem <= '0;
            done             <= 1'b0;
            rd_ptr           <= '0;
            if (run && (seq_len != 4'd0)) begin
              state <= PLAY;
            end
          end
          PLAY: begin
            if (!run) begin
              state            <= IDLE;
              rd_ptr           <= '0;
              done             <= 1'b0;
              CurrentState_mem <= '0;
            end else begin
              // Output follows the pointer register, one cycle behind it
              CurrentState_mem <= mem[rd_ptr];
              if (tick) begin
                if (at_last) begin
`ifdef SEQ_LOOP_EN
                  rd_ptr <= '0;
`else
                  state <= HOLD;
                  done  <= 1'b1;
`endif
                end else begin
                  rd_ptr <= rd_ptr + PW'(1);
                end
              end
            end
          end
          HOLD: begin
            if (!run) begin
              state            <= IDLE;
              rd_ptr           <= '0;
              done             <= 1'b0;
              CurrentState_mem <= '0;
            end else begin
              CurrentState_mem <= mem[rd_ptr];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_state_sequencer.sv
// tb_state_sequencer -- directed bench for state_sequencer at TICK_DIV=4,
// DEPTH=8. Expectations follow the build: SEQ_LOOP_EN selects wrapping
// playback, otherwise playback ends in HOLD with done=1.
module tb_state_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       rec_key;
  logic       clear;
  logic [2:0] state_in;
  logic [2:0] CurrentState_mem;
  logic [3:0] seq_len;
  logic       full;
  logic       done;

  int checks   = 0;
  int failures = 0;

`ifdef SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  state_sequencer #(
    .TICK_DIV(4),
    .DEPTH   (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .run             (run),
    .rec_key         (rec_key),
    .clear           (clear),
    .state_in        (state_in),
    .CurrentState_mem(CurrentState_mem),
    .seq_len         (seq_len),
    .full            (full),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs and samples sit 1 time unit after the edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One record request with the key held for 10 cycles
  task automatic record(input logic [2:0] val);
    state_in = val;
    rec_key  = 1'b1;
    step(10);
    rec_key  = 1'b0;
    step(2);
  endtask

  logic [2:0] seq3 [3]  = '{3'd5, 3'd2, 3'd7};
  logic [2:0] seq8 [8]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6};

  initial begin
    reset = 1'b1; run = 1'b0; rec_key = 1'b0; clear = 1'b0; state_in = '0;
    step(2);
    reset = 1'b0;
    step(1);
    check("reset_out", CurrentState_mem, 0);
    check("reset_len", seq_len, 0);
    check("reset_full", full, 0);
    check("reset_done", done, 0);

    // Record 5,2,7; a held key must record once
    record(3'd5);
    check("rec_once", seq_len, 1);
    record(3'd2);
    record(3'd7);
    check("rec_len3", seq_len, 3);
    check("rec_full0", full, 0);

    // Playback of 5,2,7, each entry held 4 cycles after one IDLE->PLAY edge
    run = 1'b1;
    step(1);
    check("play_entry_out", CurrentState_mem, 0);
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("play_out", CurrentState_mem, seq3[i / 4]);
      if (i < 11) check("play_done0", done, 0);
      else        check("play_done_last", done, LOOP ? 0 : 1);
    end
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("after_out", CurrentState_mem, LOOP ? seq3[i / 4] : 3'd7);
      check("after_done", done, LOOP ? 0 : 1);
    end
    run = 1'b0;
    step(1);
    check("stop_out", CurrentState_mem, 0);
    check("stop_done", done, 0);
    check("stop_len", seq_len, 3);

    // Fill to DEPTH, ninth edge ignored
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clear_len", seq_len, 0);
    for (int i = 0; i < 8; i++) record(seq8[i]);
    check("fill_full", full, 1);
    record(3'd3);
    check("ninth_len", seq_len, 8);
    check("ninth_full", full, 1);
    run = 1'b1;
    step(1);
    for (int i = 0; i < 32; i++) begin
      step(1);
      if ((i % 4) == 0) check("fill_play", CurrentState_mem, seq8[i / 4]);
    end
    step(1);
    check("fill_wrap", CurrentState_mem, LOOP ? 3'd1 : 3'd6);
    run = 1'b0;
    step(1);

    // clear coinciding with a record edge
    state_in = 3'd4;
    rec_key  = 1'b1;
    clear    = 1'b1;
    step(1);
    clear    = 1'b0;
    check("clrrec_len", seq_len, 0);
    check("clrrec_full", full, 0);
    step(3);
    check("clrrec_held", seq_len, 0);
    rec_key = 1'b0;
    step(2);

    // run with an empty sequence stays idle
    run = 1'b1;
    step(6);
    check("empty_run_out", CurrentState_mem, 0);
    check("empty_run_done", done, 0);
    run = 1'b0;
    step(1);

    // reset in the middle of playback
    record(3'd5);
    record(3'd2);
    record(3'd7);
    run = 1'b1;
    step(7);
    check("mid_play_out", CurrentState_mem, 2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("rst_play_out", CurrentState_mem, 0);
    check("rst_play_len", seq_len, 0);
    check("rst_play_done", done, 0);
    step(6);
    check("rst_run_out", CurrentState_mem, 0);
    check("rst_run_len", seq_len, 0);
    run = 1'b0;
    step(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
